// File: rtl/spi_pkg.sv
// Shared constants and helpers for the SPI slave receive path.
package spi_pkg;

    localparam int CHAR_LEN_MAX = 15;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spi_fifo_mem.sv
// FIFO storage: one synchronous write port, asynchronous read port, no reset on contents.
module spi_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write one entry per accepted push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/spi_slave_rx_fifo.sv
// First-word-fall-through receive FIFO for the SPI slave character engine.
// Optional start-of-frame tagging is built when SPI_RXFIFO_SOF_TAG_EN is defined.
module spi_slave_rx_fifo
    import spi_pkg::*;
#(
    parameter int CHAR_NBITS = 32,
    parameter int DEPTH      = 8
) (
    input  logic                          S_SYSCLK,
    input  logic                          S_RESET,
    input  logic                          S_ENABLE,
    input  logic                          S_CHAR_DONE,
    input  logic [CHAR_NBITS-1:0]         S_RCHAR,
    input  logic [3:0]                    S_CHAR_LEN,
    input  logic                          S_SPI_CS,
    output logic                          M_VALID,
    input  logic                          M_READY,
    output logic [CHAR_NBITS-1:0]         M_DATA,
    output logic                          M_SOF,
    output logic [level_width(DEPTH)-1:0] S_LEVEL,
    output logic                          S_FULL,
    output logic                          S_OVF,
    input  logic                          S_OVF_CLR
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);
`ifdef SPI_RXFIFO_SOF_TAG_EN
    localparam int MW = CHAR_NBITS + 1;
`else
    localparam int MW = CHAR_NBITS;
`endif

    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LVL_ONE  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [AW-1:0]         wptr_r;
    logic [AW-1:0]         rptr_r;
    logic [LW-1:0]         level_r;
    logic [LW-1:0]         level_nxt_s;
    logic                  valid_r;
    logic                  full_r;
    logic                  ovf_r;
    logic                  push_req_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  we_s;
    logic [CHAR_NBITS-1:0] masked_s;
    logic [MW-1:0]         wdata_s;
    logic [MW-1:0]         rdata_s;

    // Bits above the programmed length, and everything from bit 16 up, never reach storage.
    function automatic logic [CHAR_NBITS-1:0] mask_char(input logic [CHAR_NBITS-1:0] c,
                                                        input logic [3:0]            len);
        logic [CHAR_NBITS-1:0] r;
        for (int i = 0; i < CHAR_NBITS; i++) begin
            r[i] = ((i <= int'(len)) && (i <= CHAR_LEN_MAX)) ? c[i] : 1'b0;
        end
        return r;
    endfunction

    assign push_req_s = S_CHAR_DONE & S_ENABLE;
    assign pop_s      = valid_r & M_READY;
    assign push_s     = push_req_s & (~full_r | pop_s);
    assign drop_s     = push_req_s & full_r & ~pop_s;
    assign we_s       = push_s & ~S_RESET;
    assign masked_s   = mask_char(S_RCHAR, S_CHAR_LEN);

    // Next occupancy: simultaneous push and pop leave the level unchanged.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // Pointers, level and the flags derived from it; disable flushes like a reset but keeps overflow.
    always_ff @(posedge S_SYSCLK) begin
        if (S_RESET || !S_ENABLE) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            level_r <= {LW{1'b0}};
            valid_r <= 1'b0;
            full_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            level_r <= level_nxt_s;
            valid_r <= (level_nxt_s != {LW{1'b0}});
            full_r  <= (level_nxt_s == LVL_FULL);
        end
    end

    // Sticky overflow; a new drop beats a clear in the same cycle.
    always_ff @(posedge S_SYSCLK) begin
        if (S_RESET) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (S_OVF_CLR) begin
            ovf_r <= 1'b0;
        end
    end

`ifdef SPI_RXFIFO_SOF_TAG_EN
    logic cs_q_r;
    logic armed_r;
    logic cs_fall_s;

    assign cs_fall_s = cs_q_r & ~S_SPI_CS;

    // Arm on a chip-select falling edge; any push attempt, even a dropped one, disarms.
    always_ff @(posedge S_SYSCLK) begin
        if (S_RESET) begin
            cs_q_r  <= 1'b1;
            armed_r <= 1'b1;
        end else begin
            cs_q_r <= S_SPI_CS;
            if (cs_fall_s) begin
                armed_r <= 1'b1;
            end else if (push_req_s) begin
                armed_r <= 1'b0;
            end
        end
    end

    assign wdata_s = {armed_r, masked_s};
    assign M_SOF   = rdata_s[CHAR_NBITS];
`else
    logic unused_cs_s;

    assign unused_cs_s = S_SPI_CS;
    assign wdata_s     = masked_s;
    assign M_SOF       = 1'b0;
`endif

    spi_fifo_mem #(
        .WIDTH (MW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (S_SYSCLK),
        .we    (we_s),
        .waddr (wptr_r),
        .wdata (wdata_s),
        .raddr (rptr_r),
        .rdata (rdata_s)
    );

    assign M_DATA  = rdata_s[CHAR_NBITS-1:0];
    assign M_VALID = valid_r;
    assign S_LEVEL = level_r;
    assign S_FULL  = full_r;
    assign S_OVF   = ovf_r;

endmodule

// File: tb/tb_spi_slave_rx_fifo.sv
// Directed bench for spi_slave_rx_fifo (DEPTH=8, CHAR_NBITS=32); SOF expectations follow SPI_RXFIFO_SOF_TAG_EN.
module tb_spi_slave_rx_fifo;

    localparam int CW = 32;
`ifdef SPI_RXFIFO_SOF_TAG_EN
    localparam logic SOF_EN = 1'b1;
`else
    localparam logic SOF_EN = 1'b0;
`endif

    logic          S_SYSCLK = 1'b0;
    logic          S_RESET;
    logic          S_ENABLE;
    logic          S_CHAR_DONE;
    logic [CW-1:0] S_RCHAR;
    logic [3:0]    S_CHAR_LEN;
    logic          S_SPI_CS;
    logic          M_VALID;
    logic          M_READY;
    logic [CW-1:0] M_DATA;
    logic          M_SOF;
    logic [3:0]    S_LEVEL;
    logic          S_FULL;
    logic          S_OVF;
    logic          S_OVF_CLR;

    always #5 S_SYSCLK = ~S_SYSCLK;

    spi_slave_rx_fifo #(.CHAR_NBITS(CW), .DEPTH(8)) dut (
        .S_SYSCLK    (S_SYSCLK),
        .S_RESET     (S_RESET),
        .S_ENABLE    (S_ENABLE),
        .S_CHAR_DONE (S_CHAR_DONE),
        .S_RCHAR     (S_RCHAR),
        .S_CHAR_LEN  (S_CHAR_LEN),
        .S_SPI_CS    (S_SPI_CS),
        .M_VALID     (M_VALID),
        .M_READY     (M_READY),
        .M_DATA      (M_DATA),
        .M_SOF       (M_SOF),
        .S_LEVEL     (S_LEVEL),
        .S_FULL      (S_FULL),
        .S_OVF       (S_OVF),
        .S_OVF_CLR   (S_OVF_CLR)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic        done;
        logic [31:0] ch;
        logic [3:0]  len;
        logic        rdy;
        logic        clr;
        logic        e_valid;
        logic [3:0]  e_level;
        logic        e_full;
        logic        e_ovf;
        logic        e_chkd;
        logic [31:0] e_data;
    } vec_t;

    vec_t        vt [8];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] expq [$];
    logic        sofq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic rst, input logic en, input logic done, input logic [31:0] ch,
                          input logic [3:0] len, input logic rdy, input logic clr);
        S_RESET     = rst;
        S_ENABLE    = en;
        S_CHAR_DONE = done;
        S_RCHAR     = ch;
        S_CHAR_LEN  = len;
        M_READY     = rdy;
        S_OVF_CLR   = clr;
    endtask

    task automatic tick();
        @(posedge S_SYSCLK);
        #1;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b1, 1'b0, 32'h0, 4'd15, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [31:0] v, input logic sof);
        set_in(1'b0, 1'b1, 1'b1, v, 4'd15, 1'b0, 1'b0);
        tick();
        expq.push_back(v & 32'h0000ffff);
        sofq.push_back(sof);
        idle();
    endtask

    task automatic drain(input string name, input logic do_sof);
        logic e_sof;
        for (int n = 0; n < 64 && expq.size() > 0; n++) begin
            chk({name, "_valid"}, 32'(M_VALID), 32'd1);
            chk({name, "_data"}, M_DATA, expq.pop_front());
            e_sof = sofq.pop_front();
            if (do_sof) chk({name, "_sof"}, 32'(M_SOF), 32'(e_sof));
            M_READY = 1'b1;
            tick();
            M_READY = 1'b0;
        end
        chk({name, "_empty"}, 32'(M_VALID), 32'd0);
        expq.delete();
        sofq.delete();
    endtask

    initial begin
        S_SPI_CS = 1'b1;
        idle();

        // Field order: rst en done ch len rdy clr | valid level full ovf chk_data data
        vt[0] = '{1'b1, 1'b1, 1'b0, 32'h0,        4'd0,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[1] = '{1'b0, 1'b1, 1'b1, 32'h1faa1234, 4'd7,  1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 32'h00000034};
        vt[2] = '{1'b0, 1'b1, 1'b0, 32'h0,        4'd0,  1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[3] = '{1'b0, 1'b1, 1'b1, 32'hffffffff, 4'd15, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 32'h0000ffff};
        vt[4] = '{1'b0, 1'b1, 1'b1, 32'h12345678, 4'd11, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 32'h00000678};
        vt[5] = '{1'b0, 1'b1, 1'b0, 32'h0,        4'd0,  1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[6] = '{1'b0, 1'b1, 1'b0, 32'h0,        4'd0,  1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[7] = '{1'b0, 1'b0, 1'b1, 32'h0000beef, 4'd15, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0};

        for (int i = 0; i < 8; i++) begin
            set_in(vt[i].rst, vt[i].en, vt[i].done, vt[i].ch, vt[i].len, vt[i].rdy, vt[i].clr);
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(M_VALID), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d_level", i), 32'(S_LEVEL), 32'(vt[i].e_level));
            chk($sformatf("vec%0d_full", i),  32'(S_FULL),  32'(vt[i].e_full));
            chk($sformatf("vec%0d_ovf", i),   32'(S_OVF),   32'(vt[i].e_ovf));
            if (vt[i].e_chkd) chk($sformatf("vec%0d_data", i), M_DATA, vt[i].e_data);
        end
        idle();
        tick();

        // Fill, overflow, set-wins-over-clear, drain order, then clear.
        for (int v = 1; v <= 8; v++) push(32'(v), 1'b0);
        chk("fill_level", 32'(S_LEVEL), 32'd8);
        chk("fill_full", 32'(S_FULL), 32'd1);
        chk("fill_ovf", 32'(S_OVF), 32'd0);
        set_in(1'b0, 1'b1, 1'b1, 32'h9, 4'd15, 1'b0, 1'b0);
        tick();
        chk("ovf_set", 32'(S_OVF), 32'd1);
        chk("ovf_level", 32'(S_LEVEL), 32'd8);
        set_in(1'b0, 1'b1, 1'b1, 32'ha, 4'd15, 1'b0, 1'b1);
        tick();
        chk("ovf_set_wins", 32'(S_OVF), 32'd1);
        idle();
        drain("fill", 1'b0);
        chk("ovf_sticky", 32'(S_OVF), 32'd1);
        set_in(1'b0, 1'b1, 1'b0, 32'h0, 4'd15, 1'b0, 1'b1);
        tick();
        chk("ovf_clr", 32'(S_OVF), 32'd0);
        idle();

        // Full with simultaneous push and pop.
        for (int v = 1; v <= 8; v++) push(32'(v), 1'b0);
        chk("sim_head", M_DATA, expq[0]);
        set_in(1'b0, 1'b1, 1'b1, 32'h9, 4'd15, 1'b1, 1'b0);
        tick();
        void'(expq.pop_front());
        void'(sofq.pop_front());
        expq.push_back(32'h9);
        sofq.push_back(1'b0);
        idle();
        chk("sim_level", 32'(S_LEVEL), 32'd8);
        chk("sim_full", 32'(S_FULL), 32'd1);
        chk("sim_ovf", 32'(S_OVF), 32'd0);
        drain("sim", 1'b0);

        // Wrap-around: push on even cycles, pop on odd cycles.
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 1) begin
                chk("wrap_valid", 32'(M_VALID), 32'd1);
                chk("wrap_data", M_DATA, expq.pop_front());
                void'(sofq.pop_front());
            end
            set_in(1'b0, 1'b1, (i % 2 == 0), 32'h100 + 32'(i / 2), 4'd15, (i % 2 == 1), 1'b0);
            tick();
            if (i % 2 == 0) begin
                expq.push_back(32'h100 + 32'(i / 2));
                sofq.push_back(1'b0);
            end
        end
        idle();
        chk("wrap_ovf", 32'(S_OVF), 32'd0);
        drain("wrap", 1'b0);

        // Reset mid-operation with overflow set and push/pop requested.
        for (int v = 1; v <= 8; v++) push(32'(v), 1'b0);
        push(32'h9, 1'b0);
        chk("rst_pre_ovf", 32'(S_OVF), 32'd1);
        set_in(1'b0, 1'b1, 1'b0, 32'h0, 4'd15, 1'b1, 1'b0);
        repeat (3) tick();
        idle();
        chk("rst_pre_level", 32'(S_LEVEL), 32'd5);
        set_in(1'b1, 1'b1, 1'b1, 32'h77, 4'd15, 1'b1, 1'b0);
        tick();
        idle();
        chk("rst_level", 32'(S_LEVEL), 32'd0);
        chk("rst_valid", 32'(M_VALID), 32'd0);
        chk("rst_ovf", 32'(S_OVF), 32'd0);
        chk("rst_full", 32'(S_FULL), 32'd0);
        expq.delete();
        sofq.delete();

        // Disable flushes but keeps the overflow flag.
        for (int v = 1; v <= 9; v++) push(32'(v), 1'b0);
        chk("en_pre_ovf", 32'(S_OVF), 32'd1);
        set_in(1'b0, 1'b0, 1'b1, 32'h55, 4'd15, 1'b0, 1'b0);
        tick();
        chk("en_level", 32'(S_LEVEL), 32'd0);
        chk("en_valid", 32'(M_VALID), 32'd0);
        chk("en_ovf", 32'(S_OVF), 32'd1);
        tick();
        chk("en_push_ignored", 32'(S_LEVEL), 32'd0);
        idle();
        tick();
        chk("en_back_level", 32'(S_LEVEL), 32'd0);
        expq.delete();
        sofq.delete();

        // SOF tagging across two chip-select frames.
        set_in(1'b1, 1'b1, 1'b0, 32'h0, 4'd15, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        S_SPI_CS = 1'b0;
        tick();
        push(32'h11, SOF_EN);
        push(32'h22, 1'b0);
        push(32'h33, 1'b0);
        S_SPI_CS = 1'b1;
        tick();
        S_SPI_CS = 1'b0;
        tick();
        push(32'h44, SOF_EN);
        push(32'h55, 1'b0);
        drain("sof", 1'b1);
        S_SPI_CS = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
